// File: rtl/core_pkg.sv
// Shared definitions for the core_seq instruction sequencer.
//   - inst bundle bit positions and the packed field view (inst_t)
//   - idle value of the bundle (memories deselected, no strobes)
//   - sequencer state encoding
//   - small helpers to build and flatten bundles
package core_pkg;

  localparam int unsigned INST_W = 35;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned KIJ_W  = 4;

  // Bit positions of the core inst bundle
  localparam int unsigned LOAD_BIT     = 0;
  localparam int unsigned EXECUTE_BIT  = 1;
  localparam int unsigned L0_WR_BIT    = 2;
  localparam int unsigned L0_RD_BIT    = 3;
  localparam int unsigned IFIFO_RD_BIT = 4;
  localparam int unsigned IFIFO_WR_BIT = 5;
  localparam int unsigned OFIFO_RD_BIT = 6;
  localparam int unsigned A_XMEM_LSB   = 7;
  localparam int unsigned A_XMEM_MSB   = 17;
  localparam int unsigned WEN_XMEM_BIT = 18;
  localparam int unsigned CEN_XMEM_BIT = 19;
  localparam int unsigned A_PMEM_LSB   = 20;
  localparam int unsigned A_PMEM_MSB   = 30;
  localparam int unsigned WEN_PMEM_BIT = 31;
  localparam int unsigned CEN_PMEM_BIT = 32;
  localparam int unsigned ACC_BIT      = 33;
  localparam int unsigned MODE_W_BIT   = 34;

  // Field view of the bundle, MSB first so it overlays the bit positions above
  typedef struct packed {
    logic              mode_w;
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  // Both memories deselected with write-enables inactive, every strobe low
  localparam inst_t INST_IDLE = '{
    mode_w:   1'b0,
    acc:      1'b0,
    cen_pmem: 1'b1,
    wen_pmem: 1'b1,
    a_pmem:   '0,
    cen_xmem: 1'b1,
    wen_xmem: 1'b1,
    a_xmem:   '0,
    ofifo_rd: 1'b0,
    ififo_wr: 1'b0,
    ififo_rd: 1'b0,
    l0_rd:    1'b0,
    l0_wr:    1'b0,
    execute:  1'b0,
    load:     1'b0
  };

  typedef enum logic [2:0] {
    IDLE,
    WRD,
    KLD,
    XRD,
    DRN,
    ACC,
    ORD
  } state_t;

  // Idle bundle carrying the weight precision of the running pass
  function automatic inst_t idle_inst(input logic mode);
    inst_t t;
    t        = INST_IDLE;
    t.mode_w = mode;
    return t;
  endfunction

  // Flatten the field view into the core bit layout
  function automatic logic [INST_W-1:0] inst_pack(input inst_t t);
    return t;
  endfunction

endpackage

// File: rtl/core_seq.sv
// core_seq: instruction sequencer for the 8x8 MAC core.
// Runs one convolution pass: per kernel index load a weight tile into L0 and
// the array, stream activations through execute, drain the array and
// accumulate psums into pmem; finally empty the OFIFO.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             pulse, accepted only while idle
//   mode_w_in         weight precision, captured on start, drives inst[34]
//   w_base/x_base/p_base  xmem weight / xmem activation / pmem psum bases
//   ofifo_valid       OFIFO non-empty, from core
//   inst              35-bit core instruction bundle
//   busy              high in every state other than IDLE
//   done              one-cycle pulse on the return to IDLE
//   kij_idx           current kernel index
module core_seq
  import core_pkg::*;
#(
  parameter int unsigned row       = 8,
  parameter int unsigned col       = 8,
  parameter int unsigned len_kij   = 9,
  parameter int unsigned len_nij   = 36,
  parameter int unsigned drain_cyc = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_w_in,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [KIJ_W-1:0]  kij_idx
);

  // Counter must cover the longest phase: WRD (row+1), KLD (col),
  // XRD (len_nij+1), DRN (drain_cyc), ACC (2*len_nij)
  localparam int unsigned CNT_MAX_A = (row > col) ? row : col;
  localparam int unsigned CNT_MAX_B = (2 * len_nij > drain_cyc) ? 2 * len_nij : drain_cyc;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WRD_LAST  = CNT_W'(row);           // extra cycle for the last l0_wr
  localparam logic [CNT_W-1:0] WRD_RDEND = CNT_W'(row - 1);       // last weight read
  localparam logic [CNT_W-1:0] KLD_LAST  = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] XRD_LAST  = CNT_W'(len_nij);       // extra cycle for the last execute
  localparam logic [CNT_W-1:0] XRD_RDEND = CNT_W'(len_nij - 1);   // last activation read
  localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(drain_cyc - 1);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(2 * len_nij - 1);
  localparam logic [CNT_W-1:0] ORD_LAST  = CNT_W'(len_nij - 1);
  localparam logic [KIJ_W-1:0] KIJ_LAST  = KIJ_W'(len_kij - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [KIJ_W-1:0]   kij;
  logic               mode_w;
  inst_t              inst_q;
  inst_t              inst_out;
  logic               ofifo_rd_c;

  // Weight tile k, row r lives at w_base + k*col + r (wraps in ADDR_W bits)
  function automatic logic [ADDR_W-1:0] w_addr(input logic [KIJ_W-1:0] k,
                                               input logic [CNT_W-1:0] r);
    return ADDR_W'(w_base + ADDR_W'(32'(k) * col) + ADDR_W'(r));
  endfunction

  function automatic logic [ADDR_W-1:0] x_addr(input logic [CNT_W-1:0] n);
    return ADDR_W'(x_base + ADDR_W'(n));
  endfunction

  // ACC counts two cycles per pixel, so the pixel index is cnt/2
  function automatic logic [ADDR_W-1:0] p_addr(input logic [CNT_W-1:0] c);
    return ADDR_W'(p_base + ADDR_W'(c >> 1));
  endfunction

  // Sequencer: state, counters and the registered bundle for the next cycle.
  // inst_q always describes the cycle the FSM is entering, so consumer strobes
  // that follow a read are set on the edge after that read's cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      kij    <= '0;
      mode_w <= 1'b0;
      inst_q <= INST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done   <= 1'b0;
      inst_q <= idle_inst(mode_w);
      case (state)
        IDLE: begin
          inst_q <= INST_IDLE;
          if (start) begin
            state           <= WRD;
            cnt             <= '0;
            kij             <= '0;
            mode_w          <= mode_w_in;
            busy            <= 1'b1;
            inst_q          <= idle_inst(mode_w_in);
            inst_q.cen_xmem <= 1'b0;
            inst_q.a_xmem   <= w_addr(KIJ_W'(0), '0);
          end
        end

        WRD: begin
          if (cnt == WRD_LAST) begin
            state       <= KLD;
            cnt         <= '0;
            inst_q.load <= 1'b1;
          end else begin
            cnt          <= cnt + CNT_W'(1);
            inst_q.l0_wr <= 1'b1;
            if (cnt != WRD_RDEND) begin
              inst_q.cen_xmem <= 1'b0;
              inst_q.a_xmem   <= w_addr(kij, cnt + CNT_W'(1));
            end
          end
        end

        KLD: begin
          if (cnt == KLD_LAST) begin
            state           <= XRD;
            cnt             <= '0;
            inst_q.cen_xmem <= 1'b0;
            inst_q.a_xmem   <= x_addr('0);
          end else begin
            cnt         <= cnt + CNT_W'(1);
            inst_q.load <= 1'b1;
          end
        end

        XRD: begin
          if (cnt == XRD_LAST) begin
            state <= DRN;
            cnt   <= '0;
          end else begin
            cnt             <= cnt + CNT_W'(1);
            inst_q.execute  <= 1'b1;
            inst_q.ififo_wr <= 1'b1;
            if (cnt != XRD_RDEND) begin
              inst_q.cen_xmem <= 1'b0;
              inst_q.a_xmem   <= x_addr(cnt + CNT_W'(1));
            end
          end
        end

        DRN: begin
          if (cnt == DRN_LAST) begin
            state           <= ACC;
            cnt             <= '0;
            inst_q.cen_pmem <= 1'b0;
            inst_q.a_pmem   <= p_addr('0);
            inst_q.acc      <= (kij != '0);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Even cnt: pmem read of pixel cnt/2; odd cnt: write back to it
        ACC: begin
          if (!cnt[0]) begin
            cnt             <= cnt + CNT_W'(1);
            inst_q.cen_pmem <= 1'b0;
            inst_q.wen_pmem <= 1'b0;
            inst_q.a_pmem   <= p_addr(cnt);
            inst_q.acc      <= (kij != '0);
          end else if (cnt != ACC_LAST) begin
            cnt             <= cnt + CNT_W'(1);
            inst_q.cen_pmem <= 1'b0;
            inst_q.a_pmem   <= p_addr(cnt + CNT_W'(1));
            inst_q.acc      <= (kij != '0);
          end else if (kij != KIJ_LAST) begin
            state           <= WRD;
            cnt             <= '0;
            kij             <= kij + KIJ_W'(1);
            inst_q.cen_xmem <= 1'b0;
            inst_q.a_xmem   <= w_addr(kij + KIJ_W'(1), '0);
          end else begin
            state <= ORD;
            cnt   <= '0;
          end
        end

        // Count OFIFO reads; the read strobe itself is gated combinationally
        ORD: begin
          if (ofifo_valid) begin
            if (cnt == ORD_LAST) begin
              state  <= IDLE;
              cnt    <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              inst_q <= INST_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy   <= 1'b0;
          inst_q <= INST_IDLE;
        end
      endcase
    end
  end

  // OFIFO read follows valid directly so an empty FIFO is never popped
  assign ofifo_rd_c = (state == ORD) && ofifo_valid;

  // Merge the combinational OFIFO read into the registered bundle
  always_comb begin
    inst_out          = inst_q;
    inst_out.ofifo_rd = ofifo_rd_c;
  end

  assign inst    = inst_pack(inst_out);
  assign kij_idx = kij;

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq.
// Stimulus tasks push the whole expected cycle trace of a pass (built from the
// phase rules: weight reads, loads, activation stream, drain, pmem
// read/write pairs) into a queue; a negedge monitor pops one entry per busy
// cycle and compares, then checks OFIFO draining and the done pulse.
module tb_core_seq;

  localparam int unsigned ROW     = 8;
  localparam int unsigned COL     = 8;
  localparam int unsigned LEN_KIJ = 3;
  localparam int unsigned LEN_NIJ = 4;
  localparam int unsigned DRAIN   = 16;

  // Bundle bit positions written out independently of the design package
  localparam int B_LOAD = 0;
  localparam int B_EXEC = 1;
  localparam int B_L0WR = 2;
  localparam int B_IFWR = 5;
  localparam int B_OFRD = 6;
  localparam int AX_LO  = 7;
  localparam int B_CENX = 19;
  localparam int AP_LO  = 20;
  localparam int B_WENP = 31;
  localparam int B_CENP = 32;
  localparam int B_ACC  = 33;
  localparam int B_MODE = 34;

  localparam logic [34:0] IDLE_LIT = 35'h1_800C_0000;

  typedef struct packed {
    logic [3:0]  kij;
    logic [34:0] inst;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode_w_in;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic [10:0] p_base;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  core_seq #(
    .row      (ROW),
    .col      (COL),
    .len_kij  (LEN_KIJ),
    .len_nij  (LEN_NIJ),
    .drain_cyc(DRAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode_w_in  (mode_w_in),
    .w_base     (w_base),
    .x_base     (x_base),
    .p_base     (p_base),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .kij_idx    (kij_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       trace[$];
  bit         pass_active;
  bit         expect_end;
  bit         expect_abort;
  bit         use_pat;
  logic       cur_mode;
  int         ord_reads;
  int         pat_idx;
  int         checks;
  int         errors;
  logic [5:0] pat_bits;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] idle_m(input logic mode);
    logic [34:0] v;
    v         = IDLE_LIT;
    v[B_MODE] = mode;
    return v;
  endfunction

  // Reference model: expected bundle for every cycle before the OFIFO drain
  task automatic build_trace(input logic mode, input int w, input int x, input int p);
    logic [34:0] v;
    for (int k = 0; k < int'(LEN_KIJ); k++) begin
      for (int r = 0; r <= int'(ROW); r++) begin
        v = idle_m(mode);
        if (r < int'(ROW)) begin
          v[B_CENX]      = 1'b0;
          v[AX_LO +: 11] = 11'((w + k * int'(COL) + r) % 2048);
        end
        if (r > 0) v[B_L0WR] = 1'b1;
        trace.push_back({4'(k), v});
      end
      for (int c = 0; c < int'(COL); c++) begin
        v         = idle_m(mode);
        v[B_LOAD] = 1'b1;
        trace.push_back({4'(k), v});
      end
      for (int n = 0; n <= int'(LEN_NIJ); n++) begin
        v = idle_m(mode);
        if (n < int'(LEN_NIJ)) begin
          v[B_CENX]      = 1'b0;
          v[AX_LO +: 11] = 11'((x + n) % 2048);
        end
        if (n > 0) begin
          v[B_EXEC] = 1'b1;
          v[B_IFWR] = 1'b1;
        end
        trace.push_back({4'(k), v});
      end
      for (int d = 0; d < int'(DRAIN); d++) trace.push_back({4'(k), idle_m(mode)});
      for (int n = 0; n < int'(LEN_NIJ); n++) begin
        v              = idle_m(mode);
        v[B_CENP]      = 1'b0;
        v[AP_LO +: 11] = 11'((p + n) % 2048);
        v[B_ACC]       = (k > 0);
        trace.push_back({4'(k), v});
        v[B_WENP]      = 1'b0;
        trace.push_back({4'(k), v});
      end
    end
  endtask

  // Monitor: one comparison set per cycle, away from the active edge
  always @(negedge clk) begin
    exp_t        e;
    logic [34:0] v;
    if (expect_abort) begin
      check("abort_inst", 64'(inst), 64'(IDLE_LIT));
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_kij", 64'(kij_idx), 64'd0);
      expect_abort = 1'b0;
    end else if (expect_end) begin
      check("end_busy", 64'(busy), 64'd0);
      check("done_pulse", 64'(done), 64'd1);
      check("end_inst", 64'(inst), 64'(IDLE_LIT));
      expect_end  = 1'b0;
      pass_active = 1'b0;
      ord_reads   = 0;
    end else if (pass_active) begin
      if (!busy) begin
        check("busy_in_pass", 64'(busy), 64'd1);
        trace.delete();
        pass_active = 1'b0;
        ord_reads   = 0;
      end else if (trace.size() > 0) begin
        e = trace.pop_front();
        check("inst", 64'(inst), 64'(e.inst));
        check("kij_idx", 64'(kij_idx), 64'(e.kij));
        check("done_low", 64'(done), 64'd0);
      end else begin
        v         = idle_m(cur_mode);
        v[B_OFRD] = ofifo_valid;
        check("ord_inst", 64'(inst), 64'(v));
        check("ord_kij", 64'(kij_idx), 64'(LEN_KIJ - 1));
        if (ofifo_valid) begin
          ord_reads++;
          if (ord_reads == int'(LEN_NIJ)) expect_end = 1'b1;
        end
      end
      if (reset) begin
        trace.delete();
        pass_active  = 1'b0;
        expect_end   = 1'b0;
        ord_reads    = 0;
        expect_abort = 1'b1;
      end
    end else if (!reset) begin
      check("idle_inst", 64'(inst), 64'(IDLE_LIT));
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
    end
  end

  // OFIFO valid: fixed toggle pattern during the drain when requested, else random
  initial begin
    ofifo_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (use_pat && pass_active && !expect_end && trace.size() == 0) begin
        ofifo_valid = pat_bits[pat_idx % 6];
        pat_idx++;
      end else begin
        ofifo_valid = 1'($urandom_range(0, 1));
      end
    end
  end

  // One pass; cycle indices count from the first busy cycle (-1 = never)
  task automatic run_pass(input logic mode, input int w, input int x, input int p,
                          input bit pat, input int poke_start, input int flip_mode,
                          input int abort_at);
    bit finished;
    mode_w_in = mode;
    w_base    = 11'(w);
    x_base    = 11'(x);
    p_base    = 11'(p);
    use_pat   = pat;
    pat_idx   = 0;
    cur_mode  = mode;
    ord_reads = 0;
    build_trace(mode, w, x, p);
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    pass_active = 1'b1;
    finished    = 1'b0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      start = (c == poke_start);
      reset = (c == abort_at);
      if (c == flip_mode) mode_w_in = ~mode;
      @(posedge clk);
      #1;
      finished = !pass_active && !expect_abort && !expect_end;
    end
    start = 1'b0;
    reset = 1'b0;
    check("pass_finished", 64'(finished), 64'd1);
    if (!finished) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      trace.delete();
      pass_active  = 1'b0;
      expect_end   = 1'b0;
      expect_abort = 1'b0;
      ord_reads    = 0;
      reset        = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pass_active  = 1'b0;
    expect_end   = 1'b0;
    expect_abort = 1'b0;
    use_pat      = 1'b0;
    cur_mode     = 1'b0;
    ord_reads    = 0;
    pat_idx      = 0;
    pat_bits     = 6'b101101;   // 1,0,1,1,0,1 from bit 0 upward
    reset        = 1'b1;
    start        = 1'b0;
    mode_w_in    = 1'b0;
    w_base       = '0;
    x_base       = '0;
    p_base       = '0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_inst", 64'(inst), 64'(IDLE_LIT));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_kij", 64'(kij_idx), 64'd0);

    // Directed pass, toggling OFIFO valid, start poked during XRD (cycle 19)
    run_pass(1'b1, 0, 128, 0, 1'b1, 19, -1, -1);
    // Precision latched on start, input flipped mid-pass
    run_pass(1'b0, 40, 300, 500, 1'b0, -1, 10, -1);
    // Reset on the first ACC read of kij 0 (cycle 38): no write may follow
    run_pass(1'b1, 16, 64, 8, 1'b0, -1, -1, 38);
    // Address wrap past 2047 on weights, activations and psums
    run_pass(1'b1, 2044, 2046, 2045, 1'b0, -1, -1, -1);
    // Randomized passes with a stray start somewhere in the busy window
    for (int i = 0; i < 3; i++) begin
      run_pass(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               1'b0, int'($urandom_range(1, 130)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Instruction sequencer for the 8x8 MAC core. It generates the 35-bit inst bundle that runs one full convolution pass, replacing the hand-written testbench instruction streams.
- For each kernel index kij it loads a weight tile from xmem into L0 and the array, then streams the activations and executes.
- After the execute stream it drains the array and accumulates psums into pmem; once every kij is done it empties the OFIFO.
- Sits directly in front of core: inst out feeds core inst; ofifo_valid is fed back from core.

Parameters:
- row, 8, array rows (weight words per tile)
- col, 8, array columns
- len_kij, 9, kernel positions per pass
- len_nij, 36, output pixels per kij
- drain_cyc, 16, idle cycles after execute for the MAC pipeline to flush (row+col)
- addr_w, 11, xmem/pmem address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; accepted only in IDLE
- mode_w_in  in  1  weight precision (1 = 4-bit, 0 = 2-bit); sampled on start, drives inst[34] for the whole pass
- w_base  in  addr_w  xmem base of weights; tile k, row r is at w_base + k*col + r
- x_base  in  addr_w  xmem base of activations; pixel n is at x_base + n
- p_base  in  addr_w  pmem base; pixel n psum is at p_base + n
- ofifo_valid  in  1  from core
- inst  out  35  bundle in core bit layout: 0 load, 1 execute, 2 l0_wr, 3 l0_rd, 4 ififo_rd, 5 ififo_wr, 6 ofifo_rd, 17:7 A_xmem, 18 WEN_xmem, 19 CEN_xmem, 30:20 A_pmem, 31 WEN_pmem, 32 CEN_pmem, 33 acc, 34 mode_w
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the return to IDLE
- kij_idx  out  4  current kernel index

Behaviour:
- Reset (and the idle value of inst):
  - inst = 35'b0 except CEN_xmem = 1, CEN_pmem = 1, WEN_xmem = 1, WEN_pmem = 1.
  - busy = 0, done = 0, kij_idx = 0, all counters 0, state IDLE.
  - A reset mid-pass aborts on the next edge to these values; no pending write is completed.
- Memory access: xmem read latency is 1 cycle. Every consumer strobe (l0_wr, ififo_wr, execute) is therefore registered one cycle after the matching CEN_xmem=0 / WEN_xmem=1 read.
- States and transitions, with counter cnt:
  - IDLE: on start go to WRD; latch mode_w_in; kij_idx = 0.
  - WRD: for cnt = 0..row-1 read A_xmem = w_base + kij*col + cnt; l0_wr is high for cnt = 1..row, i.e. row pulses in total. Then go to KLD.
  - KLD: load = 1 for col cycles. Then go to XRD.
  - XRD: for cnt = 0..len_nij-1 read A_xmem = x_base + cnt. ififo_wr and execute are each high for exactly len_nij cycles, delayed one cycle from the reads. Then go to DRN.
  - DRN: all strobes low for drain_cyc cycles. Then go to ACC.
  - ACC: per pixel n, two cycles.
    - Cycle 0: pmem read, A_pmem = p_base + n.
    - Cycle 1: pmem write, same address, CEN_pmem = 0 / WEN_pmem = 0.
    - acc = 1 when kij > 0; acc = 0 when kij = 0 (overwrite).
    - After n = len_nij-1: if kij < len_kij-1, increment kij and go to WRD; otherwise go to ORD.
  - ORD: ofifo_rd = ofifo_valid, combinational gating so no read is issued while the FIFO is empty. Stay until len_nij reads are counted, then go to IDLE with done = 1.
- Never assert CEN_xmem and a write (WEN_xmem = 0); the sequencer only reads xmem.
- start while busy is ignored.
- len_kij = 1: there is no accumulation (acc = 0 throughout).
- Address arithmetic wraps modulo 2^addr_w.
- kij_idx saturates at len_kij-1.

Decomposition:
- Shared package core_pkg holds:
  - the inst bit-position localparams listed above;
  - the inst idle value constant;
  - a state enum: IDLE, WRD, KLD, XRD, DRN, ACC, ORD.
- No sub-module: a single FSM plus counters. An optional helper inst_pack (field-to-bundle packer) may be shared with the testbench.

Test Plan:
- Reset held 3 cycles, then released with start low -> inst = idle value (bits 18, 19, 31, 32 set), busy = 0, done = 0.
- start with w_base=0, x_base=128, len_kij=1, len_nij=4 ->
  - A_xmem sequence 0..7;
  - 8 l0_wr pulses, each one cycle after its read;
  - 8 load cycles;
  - reads 128..131, with execute/ififo_wr high 4 cycles;
  - 16 idle cycles;
  - 4 pmem read/write pairs at 0..3 with acc = 0.
- len_kij=3 -> weight reads at bases 0, 8, 16; acc = 0 during the kij 0 ACC phase and 1 during kij 1 and 2; kij_idx steps 0, 1, 2.
- ORD with ofifo_valid toggling 1,0,1,1,0,1 -> ofifo_rd mirrors valid; exit after the 4th read; done pulses exactly once; busy falls with it.
- start asserted during XRD -> no effect; the sequence completes unchanged. Reset asserted in ACC -> next cycle inst = idle value and no pmem write.
- mode_w_in = 0 on start, then changed to 1 mid-pass -> inst[34] stays 0 for the whole pass.
